// File: rtl/demux_router_if.sv
// demux_router_if: producer-side and consumer-side signals of the 1-to-8 router.
//   slave  modport : router view (takes I_*, O_READY; drives I_READY, O_*, ACC_CNT)
//   master modport : environment view (the opposite directions)
// Ports carried:
//   I_DATA[W], I_SEL[3], I_BCAST, I_VALID, I_READY   input handshake
//   O_DATA[8*W] (channel k at [k*W +: W]), O_VALID[8], O_READY[8]
//   ACC_CNT[CNT_W]  saturating count of accepted input words
interface demux_router_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic [W-1:0]     I_DATA;
  logic [2:0]       I_SEL;
  logic             I_BCAST;
  logic             I_VALID;
  logic             I_READY;
  logic [8*W-1:0]   O_DATA;
  logic [7:0]       O_VALID;
  logic [7:0]       O_READY;
  logic [CNT_W-1:0] ACC_CNT;

  modport slave (
    input  I_DATA, I_SEL, I_BCAST, I_VALID, O_READY,
    output I_READY, O_DATA, O_VALID, ACC_CNT
  );

  modport master (
    output I_DATA, I_SEL, I_BCAST, I_VALID, O_READY,
    input  I_READY, O_DATA, O_VALID, ACC_CNT
  );
endinterface

// File: rtl/demux_router.sv
// demux_router: registered 1-to-8 demultiplexer with optional broadcast.
// One input word per valid/ready handshake is written into the one-entry
// holding slot of the channel named by I_SEL, or into all eight slots when
// I_BCAST is set (only if every slot is free or draining this cycle).
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (clears slots and counter)
//   bus    demux_router_if.slave (input handshake, 8 output channels, ACC_CNT)

// One channel's holding register. A load wins over a drain so the slot can
// stream one word per cycle.
module demux_router_slot #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         drain;

  assign drain = valid_q & ready_i;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drain) begin
      // data_q keeps its last value once drained
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = ~valid_q | drain;
endmodule

module demux_router #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input logic           CLK,
  input logic           RST_N,
  demux_router_if.slave bus
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0]        slot_free;
  logic [NUM_LANES-1:0]        load;
  logic [NUM_LANES-1:0][W-1:0] slot_data;
  logic                        ready;
  logic                        accept;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Ready looks only at slot state and routing controls, never at I_VALID,
  // so no combinational path runs back to the producer.
  assign ready  = bus.I_BCAST ? (&slot_free) : slot_free[bus.I_SEL];
  assign accept = bus.I_VALID & ready;

  assign bus.I_READY = ready;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign load[k] = accept & (bus.I_BCAST | (bus.I_SEL == 3'(k)));

      demux_router_slot #(.W(W)) u_slot (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load_i  (load[k]),
        .data_i  (bus.I_DATA),
        .ready_i (bus.O_READY[k]),
        .valid_o (bus.O_VALID[k]),
        .data_o  (slot_data[k]),
        .free_o  (slot_free[k])
      );

      assign bus.O_DATA[k*W +: W] = slot_data[k];
    end
  endgenerate

  // Saturating counter: a broadcast is a single accept.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.ACC_CNT = cnt_q;
endmodule
